// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared constants for the hobby-servo PWM path. The PWM generator and the
// pulse decoder both import this package so that the angle-to-pulse mapping
// and its inverse use the same STEP and cannot drift apart.
// No ports (package).
// -----------------------------------------------------------------------------
package servo_pkg;

    localparam int CLK_HZ        = 50_000_000;
    localparam int DUR_CLOCK_NUM = CLK_HZ / 50;               // 20 ms frame
    localparam int DEGREE_MIN    = DUR_CLOCK_NUM * 5 / 200;   // 0.5 ms -> 0 deg
    localparam int DEGREE_MAX    = DUR_CLOCK_NUM * 25 / 200;  // 2.5 ms -> 180 deg
    localparam int TIMEOUT       = 2 * DUR_CLOCK_NUM;         // loss-of-signal limit
    localparam int ANGLE_MAX     = 180;
    localparam int STEP          = (DEGREE_MAX - DEGREE_MIN) / ANGLE_MAX;

    localparam int CNT_W  = 17;  // high counter / pulse width
    localparam int QUOT_W = 8;   // angle / quotient

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_DIV,
        ST_DONE
    } dec_state_t;

    // Clocks per degree for an arbitrary pulse range (integer division, as
    // the generator uses it).
    function automatic int step_of(input int lo, input int hi);
        return (hi - lo) / ANGLE_MAX;
    endfunction

    // The rounding bias can push the top of the range to 181/182.
    function automatic logic [QUOT_W-1:0] clamp_angle(input logic [QUOT_W-1:0] q);
        return (q > QUOT_W'(ANGLE_MAX)) ? QUOT_W'(ANGLE_MAX) : q;
    endfunction

endpackage

// File: rtl/servo_pulse_decoder_if.sv
// -----------------------------------------------------------------------------
// servo_pulse_decoder_if
// Signal bundle between a servo PWM source / result consumer and the decoder.
//   iPwm       asynchronous servo PWM input
//   oAngle     last decoded angle, 0..180
//   oValid     one-cycle pulse when oAngle/oWidth update
//   oWidth     raw high count of the last in-range pulse
//   oRangeErr  one-cycle pulse on an out-of-range pulse
//   oLost      level, no rising edge within the timeout
// master: drives iPwm, observes results.  slave: the decoder.
// -----------------------------------------------------------------------------
interface servo_pulse_decoder_if;
    import servo_pkg::*;

    logic              iPwm;
    logic [QUOT_W-1:0] oAngle;
    logic              oValid;
    logic [CNT_W-1:0]  oWidth;
    logic              oRangeErr;
    logic              oLost;

    modport master (
        output iPwm,
        input  oAngle, oValid, oWidth, oRangeErr, oLost
    );

    modport slave (
        input  iPwm,
        output oAngle, oValid, oWidth, oRangeErr, oLost
    );

endinterface

// File: rtl/servo_angle_divider.sv
// -----------------------------------------------------------------------------
// servo_angle_divider
// Serial restoring divider producing an 8-bit quotient, one bit per clock,
// always 8 clocks. The first bit is resolved on the start edge itself, so
// done pulses on the 8th edge counting the start edge.
//   clk       system clock
//   rst       asynchronous active-high reset
//   start     one-cycle pulse, samples dividend/divisor
//   dividend  numerator (quotient must fit in 8 bits)
//   divisor   denominator
//   quotient  result, valid from the done pulse until the next start
//   done      one-cycle pulse when quotient is final
// -----------------------------------------------------------------------------
module servo_angle_divider
    import servo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  dividend,
    input  logic [CNT_W-1:0]  divisor,
    output logic [QUOT_W-1:0] quotient,
    output logic              done
);

    localparam int         DW   = CNT_W + QUOT_W;
    localparam logic [2:0] LAST = 3'(QUOT_W - 2);  // busy iterations after start

    logic [CNT_W-1:0] rem, cur_rem, next_rem;
    logic [DW-1:0]    den, cur_den;
    logic [2:0]       iter;
    logic             busy;
    logic             fits;

    // The divisor is pre-shifted to the MSB quotient position and walks right
    // one place per iteration, so the remainder never needs shifting.
    always_comb begin
        cur_rem  = start ? dividend : rem;
        cur_den  = start ? (DW'(divisor) << (QUOT_W - 1)) : den;
        fits     = {{QUOT_W{1'b0}}, cur_rem} >= cur_den;
        next_rem = fits ? cur_rem - cur_den[CNT_W-1:0] : cur_rem;
    end

    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            den      <= '0;
            iter     <= '0;
            busy     <= 1'b0;
            quotient <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= next_rem;
                den      <= cur_den >> 1;
                quotient <= {{(QUOT_W-1){1'b0}}, fits};
                iter     <= '0;
                busy     <= 1'b1;
            end else if (busy) begin
                rem      <= next_rem;
                den      <= den >> 1;
                quotient <= {quotient[QUOT_W-2:0], fits};
                iter     <= iter + 3'd1;
                if (iter == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/servo_pulse_decoder.sv
// -----------------------------------------------------------------------------
// servo_pulse_decoder
// Measures the high time of a 50 Hz servo PWM signal and converts it back to
// a 0..180 degree angle (inverse of the servo PWM generator mapping).
//   iClk  system clock
//   iRst  asynchronous active-high reset
//   bus   servo_pulse_decoder_if.slave: iPwm in; oAngle, oValid, oWidth,
//         oRangeErr, oLost out
// Parameters default to the 50 MHz system values; a bench may shrink them.
// Latency from the first clock sampling iPwm low: oRangeErr +3, oValid +12.
// -----------------------------------------------------------------------------
module servo_pulse_decoder
    import servo_pkg::*;
#(
    parameter int DEG_MIN      = DEGREE_MIN,
    parameter int DEG_MAX      = DEGREE_MAX,
    parameter int TIMEOUT_CLKS = TIMEOUT
) (
    input  logic                  iClk,
    input  logic                  iRst,
    servo_pulse_decoder_if.slave  bus
);

    localparam int               STEP_P   = step_of(DEG_MIN, DEG_MAX);
    localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(DEG_MIN);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEG_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEG_MAX + 1);
    localparam logic [CNT_W-1:0] DIV_BIAS = CNT_W'(STEP_P / 2);
    localparam logic [CNT_W-1:0] DIVISOR  = CNT_W'(STEP_P);
    localparam int               TMO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_END  = TMO_W'(TIMEOUT_CLKS);

    dec_state_t        state, next_state;
    logic [1:0]        sync_q;
    logic              pwm_q;
    logic              rise, fall;
    logic              rise_q, fall_q;
    logic [1:0]        primed;
    logic              armed;
    logic              rise_pend;
    logic [CNT_W-1:0]  high_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              in_range;
    logic [CNT_W-1:0]  dividend;
    logic [CNT_W-1:0]  width_hold;
    logic              div_start;
    logic              div_done;
    logic [QUOT_W-1:0] quot;

    // A rise only counts once a real low has been seen after reset, so a
    // pulse already in progress at reset release is ignored. primed marks
    // that sync_q[1] holds a genuine sample rather than its reset value.
    assign rise = sync_q[1] & ~pwm_q & armed;
    assign fall = ~sync_q[1] & pwm_q;

    assign in_range = (high_cnt >= CNT_MIN) && (high_cnt <= CNT_MAX);
    assign dividend = high_cnt - CNT_MIN + DIV_BIAS;  // rounds to nearest degree

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sync_q   <= '0;
            pwm_q    <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            primed   <= '0;
            armed    <= 1'b0;
            high_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.iPwm};
            pwm_q  <= sync_q[1];
            rise_q <= rise;
            fall_q <= fall;
            primed <= {primed[0], 1'b1};
            if (primed[1] && !sync_q[1]) begin
                armed <= 1'b1;
            end

            if (rise) begin
                high_cnt <= CNT_W'(1);
            end else if (sync_q[1] && high_cnt != CNT_SAT) begin
                high_cnt <= high_cnt + CNT_W'(1);
            end

            if (rise) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_END) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        next_state = state;
        div_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise_q || rise_pend) begin
                    next_state = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (fall_q) begin
                    if (in_range) begin
                        next_state = ST_DIV;
                        div_start  = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // A rise that arrives while the previous result is still being divided
    // is remembered so the FSM enters HIGH once it returns to IDLE; the high
    // counter already started on the real edge.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rise_pend <= 1'b0;
        end else if (fall_q || state == ST_IDLE) begin
            rise_pend <= 1'b0;
        end else if (rise_q && (state == ST_DIV || state == ST_DONE)) begin
            rise_pend <= 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            width_hold    <= '0;
            bus.oAngle    <= '0;
            bus.oValid    <= 1'b0;
            bus.oWidth    <= '0;
            bus.oRangeErr <= 1'b0;
            bus.oLost     <= 1'b1;
        end else begin
            if (div_start) begin
                width_hold <= high_cnt;
            end

            bus.oValid <= (state == ST_DONE);
            if (state == ST_DONE) begin
                bus.oAngle <= clamp_angle(quot);
                bus.oWidth <= width_hold;
            end

            // A fall while a result is in flight came from a pulse far
            // shorter than DEG_MIN, so it is reported as out of range.
            bus.oRangeErr <= fall_q && ((state == ST_HIGH && !in_range) ||
                                        state == ST_DIV || state == ST_DONE);

            if (tmo_cnt == TMO_END) begin
                bus.oLost <= 1'b1;
            end else if (state == ST_DONE) begin
                bus.oLost <= 1'b0;
            end
        end
    end

    servo_angle_divider u_divider (
        .clk      (iClk),
        .rst      (iRst),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (DIVISOR),
        .quotient (quot),
        .done     (div_done)
    );

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// -----------------------------------------------------------------------------
// tb_servo_pulse_decoder
// Directed bench for servo_pulse_decoder with a scaled-down pulse range:
// DEG_MIN=500, DEG_MAX=2500 -> STEP=11, timeout 5000 clocks.
// Angle a is produced by a pulse of 11*a+500 clocks; a width w decodes to
// (w-500+5)/11, clamped to 180.
// -----------------------------------------------------------------------------
module tb_servo_pulse_decoder;

    localparam int TB_MIN = 500;
    localparam int TB_MAX = 2500;
    localparam int TB_TMO = 5000;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    servo_pulse_decoder_if bus ();

    servo_pulse_decoder #(
        .DEG_MIN      (TB_MIN),
        .DEG_MAX      (TB_MAX),
        .TIMEOUT_CLKS (TB_TMO)
    ) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a high pulse of 'width' clocks, then watch 40 low clocks.
    // k = number of falling clock edges since iPwm went low.
    task automatic run_pulse(input int width, output int valid_at, output int err_at,
                             output int n_valid);
        bus.iPwm = 1'b1;
        repeat (width) @(negedge clk);
        bus.iPwm = 1'b0;
        valid_at = 0;
        err_at   = 0;
        n_valid  = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.oValid === 1'b1) begin
                n_valid++;
                if (valid_at == 0) valid_at = k;
            end
            if (bus.oRangeErr === 1'b1 && err_at == 0) err_at = k;
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.oAngle !== 8'd0 || bus.oWidth !== 17'd0 || bus.oValid !== 1'b0 ||
            bus.oRangeErr !== 1'b0 || bus.oLost !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: angle=%0d width=%0d valid=%b err=%b lost=%b, required 0 0 0 0 1",
                     bus.oAngle, bus.oWidth, bus.oValid, bus.oRangeErr, bus.oLost);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_nominal();
        int va, ea, nv;
        run_pulse(1490, va, ea, nv);
        n_tests++;
        if (va != 13 || nv != 1) begin
            n_fail++;
            $display("FAIL nominal_latency: valid at %0d (count %0d), required 13 (count 1)", va, nv);
        end
        n_tests++;
        if (bus.oAngle !== 8'd90) begin
            n_fail++;
            $display("FAIL nominal_angle: got %0d, required 90", bus.oAngle);
        end
        n_tests++;
        if (bus.oWidth !== 17'd1490) begin
            n_fail++;
            $display("FAIL nominal_width: got %0d, required 1490", bus.oWidth);
        end
        n_tests++;
        if (bus.oLost !== 1'b0 || ea != 0) begin
            n_fail++;
            $display("FAIL nominal_flags: lost=%b err_at=%0d, required lost=0 err_at=0", bus.oLost, ea);
        end
    endtask

    task automatic test_endpoints();
        int widths [4] = '{500, 2480, 2490, 2500};
        int angles [4] = '{0, 180, 180, 180};
        int va, ea, nv;
        for (int i = 0; i < 4; i++) begin
            run_pulse(widths[i], va, ea, nv);
            n_tests++;
            if (nv != 1 || bus.oAngle !== 8'(angles[i]) || bus.oWidth !== 17'(widths[i])) begin
                n_fail++;
                $display("FAIL endpoint_%0d: valids=%0d angle=%0d width=%0d, required 1 %0d %0d",
                         widths[i], nv, bus.oAngle, bus.oWidth, angles[i], widths[i]);
            end
        end
    endtask

    task automatic test_rounding();
        int widths [3] = '{995, 1000, 1001};
        int angles [3] = '{45, 45, 46};
        int va, ea, nv;
        for (int i = 0; i < 3; i++) begin
            run_pulse(widths[i], va, ea, nv);
            n_tests++;
            if (nv != 1 || bus.oAngle !== 8'(angles[i])) begin
                n_fail++;
                $display("FAIL rounding_%0d: valids=%0d angle=%0d, required 1 %0d",
                         widths[i], nv, bus.oAngle, angles[i]);
            end
        end
    endtask

    // Relies on the preceding result being 46 / 1001.
    task automatic test_range_err();
        int widths [2] = '{499, 2501};
        int va, ea, nv;
        for (int i = 0; i < 2; i++) begin
            run_pulse(widths[i], va, ea, nv);
            n_tests++;
            if (ea != 4 || nv != 0) begin
                n_fail++;
                $display("FAIL range_err_%0d: err at %0d valids=%0d, required err at 4 valids=0",
                         widths[i], ea, nv);
            end
            n_tests++;
            if (bus.oAngle !== 8'd46 || bus.oWidth !== 17'd1001) begin
                n_fail++;
                $display("FAIL range_hold_%0d: angle=%0d width=%0d, required 46 1001",
                         widths[i], bus.oAngle, bus.oWidth);
            end
        end
    endtask

    // A 3-clock glitch pulse lands while the previous result is dividing.
    task automatic test_fall_in_div();
        int va, ea, nv;
        bus.iPwm = 1'b1;
        repeat (1000) @(negedge clk);
        bus.iPwm = 1'b0;
        va = 0; ea = 0; nv = 0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            if (bus.oValid === 1'b1) begin
                nv++;
                if (va == 0) va = k;
            end
            if (bus.oRangeErr === 1'b1 && ea == 0) ea = k;
            if (k == 3) bus.iPwm = 1'b1;
            if (k == 6) bus.iPwm = 1'b0;
        end
        n_tests++;
        if (va != 13 || nv != 1 || bus.oAngle !== 8'd45 || bus.oWidth !== 17'd1000) begin
            n_fail++;
            $display("FAIL div_overlap_result: valid at %0d valids=%0d angle=%0d width=%0d, required 13 1 45 1000",
                     va, nv, bus.oAngle, bus.oWidth);
        end
        n_tests++;
        if (ea != 10) begin
            n_fail++;
            $display("FAIL div_overlap_err: err at %0d, required 10", ea);
        end
    endtask

    task automatic test_lost_low();
        int va, ea, nv;
        n_tests++;
        if (bus.oLost !== 1'b0) begin
            n_fail++;
            $display("FAIL lost_before_low: got %b, required 0", bus.oLost);
        end
        repeat (TB_TMO + 20) @(negedge clk);
        n_tests++;
        if (bus.oLost !== 1'b1) begin
            n_fail++;
            $display("FAIL lost_low: got %b, required 1", bus.oLost);
        end
        run_pulse(1490, va, ea, nv);
        n_tests++;
        if (va != 13 || bus.oLost !== 1'b0 || bus.oAngle !== 8'd90) begin
            n_fail++;
            $display("FAIL lost_low_recover: valid at %0d lost=%b angle=%0d, required 13 0 90",
                     va, bus.oLost, bus.oAngle);
        end
    endtask

    task automatic test_lost_high();
        int va, ea, nv;
        bus.iPwm = 1'b1;
        repeat (TB_TMO + 20) @(negedge clk);
        n_tests++;
        if (bus.oLost !== 1'b1) begin
            n_fail++;
            $display("FAIL lost_high: got %b, required 1", bus.oLost);
        end
        bus.iPwm = 1'b0;
        ea = 0; nv = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.oValid === 1'b1) nv++;
            if (bus.oRangeErr === 1'b1 && ea == 0) ea = k;
        end
        n_tests++;
        if (ea != 4 || nv != 0 || bus.oLost !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_high_release: err at %0d valids=%0d lost=%b, required 4 0 1",
                     ea, nv, bus.oLost);
        end
        run_pulse(1001, va, ea, nv);
        n_tests++;
        if (va != 13 || bus.oLost !== 1'b0 || bus.oAngle !== 8'd46) begin
            n_fail++;
            $display("FAIL lost_high_recover: valid at %0d lost=%b angle=%0d, required 13 0 46",
                     va, bus.oLost, bus.oAngle);
        end
    endtask

    // Reset while high; the input is still high when reset releases, so
    // that pulse must be ignored entirely.
    task automatic test_reset_mid_high();
        int ea, nv;
        bus.iPwm = 1'b1;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.oAngle !== 8'd0 || bus.oWidth !== 17'd0 || bus.oValid !== 1'b0 ||
            bus.oRangeErr !== 1'b0 || bus.oLost !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_high: angle=%0d width=%0d valid=%b err=%b lost=%b, required 0 0 0 0 1",
                     bus.oAngle, bus.oWidth, bus.oValid, bus.oRangeErr, bus.oLost);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        bus.iPwm = 1'b0;
        ea = 0; nv = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.oValid === 1'b1) nv++;
            if (bus.oRangeErr === 1'b1) ea++;
        end
        n_tests++;
        if (nv != 0 || ea != 0 || bus.oAngle !== 8'd0 || bus.oLost !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_high_ignored: valids=%0d errs=%0d angle=%0d lost=%b, required 0 0 0 1",
                     nv, ea, bus.oAngle, bus.oLost);
        end
    endtask

    task automatic test_reset_mid_div();
        int va, ea, nv;
        run_pulse(1490, va, ea, nv);
        n_tests++;
        if (va != 13 || bus.oAngle !== 8'd90) begin
            n_fail++;
            $display("FAIL post_reset_pulse: valid at %0d angle=%0d, required 13 90", va, bus.oAngle);
        end
        bus.iPwm = 1'b1;
        repeat (1001) @(negedge clk);
        bus.iPwm = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.oAngle !== 8'd0 || bus.oWidth !== 17'd0 || bus.oValid !== 1'b0 ||
            bus.oRangeErr !== 1'b0 || bus.oLost !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_div: angle=%0d width=%0d valid=%b err=%b lost=%b, required 0 0 0 0 1",
                     bus.oAngle, bus.oWidth, bus.oValid, bus.oRangeErr, bus.oLost);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.oValid === 1'b1) nv++;
        end
        n_tests++;
        if (nv != 0 || bus.oAngle !== 8'd0 || bus.oLost !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_div_no_valid: valids=%0d angle=%0d lost=%b, required 0 0 1",
                     nv, bus.oAngle, bus.oLost);
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        bus.iPwm = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_nominal();
        test_endpoints();
        test_rounding();
        test_range_err();
        test_fall_in_div();
        test_lost_low();
        test_lost_high();
        test_reset_mid_high();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_pulse_decoder.md
# servo_pulse_decoder

Measures the high time of an incoming 50 Hz hobby-servo PWM signal and converts it back to a joint angle of 0–180°. It inverts the angle-to-pulse mapping used by the servo PWM outputs, so it serves two purposes. It is the capture side for RC-receiver joint commands. It also serves as a loop-back checker on the GPIO servo lines. Outputs one angle per valid pulse, flags out-of-range pulses, and flags loss of signal.

## Interface
- CLK_HZ, 50000000, system clock frequency.
- DUR_CLOCK_NUM, CLK_HZ/50 (1000000), clocks per 20 ms frame.
- DEGREE_MIN, DUR_CLOCK_NUM*5/200 (25000), 0.5 ms pulse (0°).
- DEGREE_MAX, DUR_CLOCK_NUM*25/200 (125000), 2.5 ms pulse (180°).
- TIMEOUT, 2*DUR_CLOCK_NUM (2000000), clocks without a rising edge before the signal is declared lost.

Ports:
- iClk  in  1  system clock, 50 MHz.
- iRst  in  1  reset; **asynchronous, active-high**.
- iPwm  in  1  asynchronous servo PWM input.
- oAngle  out  8  last decoded angle, 0..180; reset 0.
- oValid  out  1  one-cycle pulse when oAngle is updated; reset 0.
- oWidth  out  17  raw high count of the last in-range pulse; reset 0.
- oRangeErr  out  1  one-cycle pulse on a pulse outside [DEGREE_MIN, DEGREE_MAX]; reset 0.
- oLost  out  1  level: no rising edge within TIMEOUT; reset 1.

## Operation
- Synchronization: iPwm passes through a 2-flop synchronizer, then one edge-detect register. All counting uses the synchronized signal.
- STEP = (DEGREE_MAX-DEGREE_MIN)/180 = 555, integer division. Using the same constant as the PWM generator guarantees that a pulse of STEP*a+DEGREE_MIN decodes to exactly a.
- The high counter clears on each rising edge and increments while the signal is high. It saturates at DEGREE_MAX+1 (17 bits).
- Falling edge with count in [DEGREE_MIN, DEGREE_MAX]:
  - Latch count into oWidth.
  - Start the divider with dividend d = count - DEGREE_MIN + STEP/2 (rounds to nearest).
  - Quotient is clamped to 180.
- Falling edge with count outside that range:
  - Pulse oRangeErr.
  - oAngle and oWidth are unchanged; the divider is not started.
- Divider: serial restoring division, 8 quotient bits, one bit per cycle, fixed 8 cycles. Since d < 256*STEP, 8 bits always suffice.
- FSM states:
  - IDLE → HIGH on rising edge.
  - HIGH → DIV on in-range fall.
  - HIGH → IDLE on out-of-range fall.
  - DIV → DONE after 8 iterations.
  - DONE → IDLE, registering oAngle and pulsing oValid.
- Timeout and oLost:
  - The timeout counter clears on every rising edge and saturates at TIMEOUT.
  - oLost sets when the counter reaches TIMEOUT, including a stuck-high input.
  - oLost clears on the next oValid.
- Simultaneous events:
  - A rising edge during DIV or DONE restarts the high counter in parallel; the divider still completes.
  - A fall during DIV cannot come from an in-range pulse, because in-range pulses take ≥ 25000 cycles. It is treated as out-of-range: oRangeErr pulses and the divider completes.
- Reset mid-operation:
  - All counters, the FSM and the synchronizer clear immediately; outputs return to their reset values.
  - The first pulse after reset is ignored if iPwm is already high when reset deasserts. It is only counted after a rising edge is seen.

## Timing
- A clean input high of N cycles produces high count N.
- oValid asserts exactly 12 cycles after the first iClk edge that samples iPwm low: 2 sync + 1 edge + 8 divide + 1 output.
- oRangeErr asserts 3 cycles after the same edge.
- oAngle and oWidth change only in the cycle oValid is high.
- Throughput: one result per PWM frame. The minimum supported frame is 13 cycles of low time after a pulse.

## Structure
- Shared package servo_pkg holds DUR_CLOCK_NUM, DEGREE_MIN, DEGREE_MAX and STEP. The PWM generator and this block both import it.
- Sub-module servo_angle_divider: serial restoring divider. Ports: start, dividend[16:0], divisor, quotient[7:0], done.

## Test plan
- Pulse 74950 cycles (90°), period 1000000 → oAngle=90, oWidth=74950, oValid 12 cycles after the fall, oLost clears.
- Pulses 25000 and 124900 → oAngle=0 and oAngle=180 respectively.
- Rounding:
  - Pulse 25000+24975+277=50252 → 45.
  - Pulse 50253 → 46.
  - Pulse 125000 → 180 (clamped).
- Pulse 24999, then pulse 125001 → oRangeErr each time, oAngle keeps its previous value, no oValid.
- Input held low, or held high, for 2000000 cycles → oLost=1. The next 74950-cycle pulse → oValid, oLost=0.
- Assert iRst in the middle of a HIGH phase and in the middle of DIV → all outputs return to reset values (oLost=1), and no oValid follows.
